// File: rtl/thread_group_sequencer.sv
// Splits one instruction into 1, 2 or 4 thread-group beats for the threads mask decoder.
// Optional SKIP_IDLE_GROUPS_EN: groups whose predicate bits are all zero are not issued.
module thread_group_sequencer #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [1:0]         in_mode,
    input  logic [7:0]         in_pred,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [3:0]         out_threads_mask,
    output logic               out_last,
    output logic               busy
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         pred_q, pred_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [3:0]         mask_q, mask_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [2:0]         nxt, later;
    logic [7:0]         pred_in;

`ifdef SKIP_IDLE_GROUPS_EN
    assign pred_in = in_pred;
`else
    // All-ones predicate makes every group of the mode qualify.
    logic unused_pred;
    assign pred_in     = 8'hFF;
    assign unused_pred = ^in_pred;
`endif

    // Group g exists for this mode and has at least one live thread; g >= group count is never ok.
    function automatic logic group_ok(input logic [1:0] mode, input logic [7:0] pred,
                                      input logic [2:0] g);
        group_ok = 1'b0;
        case (mode)
            2'b01: begin
                case (g)
                    3'd0:    group_ok = |pred[3:0];
                    3'd1:    group_ok = |pred[7:4];
                    default: group_ok = 1'b0;
                endcase
            end
            2'b10: begin
                case (g)
                    3'd0:    group_ok = |pred[1:0];
                    3'd1:    group_ok = |pred[3:2];
                    3'd2:    group_ok = |pred[5:4];
                    3'd3:    group_ok = |pred[7:6];
                    default: group_ok = 1'b0;
                endcase
            end
            default: group_ok = (g == 3'd0) && (|pred);
        endcase
    endfunction

    // Lowest qualifying group index >= start, or 4 when none remain.
    function automatic logic [2:0] first_from(input logic [1:0] mode, input logic [7:0] pred,
                                              input logic [2:0] start);
        first_from = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (3'(i) >= start && group_ok(mode, pred, 3'(i)))
                first_from = 3'(i);
        end
    endfunction

    function automatic logic [3:0] mask_of(input logic [1:0] mode, input logic [1:0] g);
        case (mode)
            2'b01:   mask_of = g[0] ? 4'b1010 : 4'b1000;
            2'b10:   mask_of = {2'b11, g};
            default: mask_of = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            mode_q  <= 2'd0;
            pred_q  <= 8'd0;
            instr_q <= '0;
            mask_q  <= 4'b0000;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            pred_q  <= pred_d;
            instr_q <= instr_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        pred_d  = pred_q;
        instr_d = instr_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        last_d  = last_q;
        nxt     = 3'd4;
        later   = 3'd4;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    instr_d = in_instr;
                    mode_d  = in_mode;
                    pred_d  = pred_in;
                    state_d = ISSUE;
                    nxt     = first_from(in_mode, pred_in, 3'd0);
                    // No qualifying group: spend one ISSUE cycle with out_valid low, then return.
                    if (nxt != 3'd4) begin
                        later   = first_from(in_mode, pred_in, nxt + 3'd1);
                        idx_d   = nxt[1:0];
                        mask_d  = mask_of(in_mode, nxt[1:0]);
                        valid_d = 1'b1;
                        last_d  = (later == 3'd4);
                    end
                end
            end
            ISSUE: begin
                if (!valid_q) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        nxt    = first_from(mode_q, pred_q, {1'b0, idx_q} + 3'd1);
                        later  = first_from(mode_q, pred_q, nxt + 3'd1);
                        idx_d  = nxt[1:0];
                        mask_d = mask_of(mode_q, nxt[1:0]);
                        last_d = (later == 3'd4);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready         = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign out_valid        = valid_q;
    assign out_instr        = instr_q;
    assign out_threads_mask = mask_q;
    assign out_last         = last_q;

endmodule

// File: tb/tb_thread_group_sequencer.sv
// Directed + randomized bench for thread_group_sequencer against a beat-list reference model.
module tb_thread_group_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_instr;
    logic [1:0]   in_mode;
    logic [7:0]   in_pred;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_instr;
    logic [3:0]   out_threads_mask;
    logic         out_last;
    logic         busy;

    int n_total = 0;
    int n_pass  = 0;
    logic [3:0] exp_q[$];

    thread_group_sequencer #(.INSTR_W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_mode(in_mode), .in_pred(in_pred),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_threads_mask(out_threads_mask), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: list every group of the mode with its predicate slice, then drop dead groups.
    function automatic void build_expected(input logic [1:0] mode, input logic [7:0] pred);
        logic [3:0] masks[$];
        logic [7:0] sel[$];
        exp_q.delete();
        if (mode == 2'b01) begin
            masks.push_back(4'b1000); sel.push_back({4'd0, pred[3:0]});
            masks.push_back(4'b1010); sel.push_back({4'd0, pred[7:4]});
        end else if (mode == 2'b10) begin
            for (int k = 0; k < 4; k++) begin
                masks.push_back(4'b1100 + 4'(k));
                sel.push_back((pred >> (2 * k)) & 8'h03);
            end
        end else begin
            masks.push_back(4'b0000); sel.push_back(pred);
        end
        for (int i = 0; i < masks.size(); i++) begin
`ifdef SKIP_IDLE_GROUPS_EN
            if (sel[i] == 8'd0) continue;
`endif
            exp_q.push_back(masks[i]);
        end
    endfunction

    task automatic run_instr(input logic [1:0] mode, input logic [7:0] pred,
                             input logic [W-1:0] instr, input int stall0, input bit rnd);
        int idx;
        int cyc;
        int n;
        build_expected(mode, pred);
        n = exp_q.size();
        check("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_mode   = mode;
        in_pred   = pred;
        in_instr  = instr;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        in_instr = $urandom;
        in_mode  = 2'($urandom_range(0, 3));
        in_pred  = 8'($urandom);
        if (n == 0) begin
            check("zero_beat_valid", 64'(out_valid), 64'd0);
            check("zero_beat_busy", 64'(in_ready), 64'd0);
            step();
            check("zero_beat_ready", 64'(in_ready), 64'd1);
            check("zero_beat_valid2", 64'(out_valid), 64'd0);
            return;
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 100) begin
            out_ready = (cyc < stall0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            check("beat_valid", 64'(out_valid), 64'd1);
            check("beat_in_ready", 64'(in_ready), 64'd0);
            check("beat_mask", 64'(out_threads_mask), 64'(exp_q[idx]));
            check("beat_last", 64'(out_last), 64'(idx == n - 1));
            check("beat_instr", 64'(out_instr), 64'(instr));
            if (out_ready) idx++;
            cyc++;
            step();
        end
        check("beats_issued", 64'(idx), 64'(n));
        check("done_valid", 64'(out_valid), 64'd0);
        check("done_last", 64'(out_last), 64'd0);
        check("done_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_mode   = 2'b00;
        in_pred   = 8'h00;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_mask", 64'(out_threads_mask), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Single all-threads beat, then four quarters, then halves with a stalled first beat.
        run_instr(2'b00, 8'hFF, 32'hA5A5_0001, 0, 1'b0);
        run_instr(2'b10, 8'hFF, 32'h1234_5678, 0, 1'b0);
        run_instr(2'b01, 8'hFF, 32'hCAFE_0003, 3, 1'b0);

        // Reset on the third quarter beat discards the instruction.
        in_valid  = 1'b1;
        in_mode   = 2'b10;
        in_pred   = 8'hFF;
        in_instr  = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("pre_rst_mask", 64'(out_threads_mask), 64'hE);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_mask", 64'(out_threads_mask), 64'd0);
        check("async_rst_instr", 64'(out_instr), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        step();
        run_instr(2'b01, 8'hFF, 32'h0000_0004, 0, 1'b0);

        // Sparse predicates matter only when group skipping is built in.
        run_instr(2'b10, 8'b0011_0000, 32'h0000_0005, 0, 1'b0);
        run_instr(2'b10, 8'h00, 32'h0000_0006, 0, 1'b0);
        run_instr(2'b11, 8'hFF, 32'h0000_0007, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [7:0] p;
            p = 8'($urandom) & 8'($urandom);
            run_instr(2'($urandom_range(0, 3)), p, $urandom, $urandom_range(0, 2), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
